proc_control: RTL

//   Control FSM for the 8-register bus processor. Holds the instruction

---
 rtl/proc_pkg.sv | 27 ++
 rtl/proc_control_if.sv | 32 +++
 rtl/proc_control_dec3to8.sv | 13 +
 rtl/proc_control.sv | 127 ++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the bus-processor control unit: opcodes, FSM states
// and the positions of the decoded fields inside the stored instruction bits.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // Only the top 9 bits of the instruction word are kept: op, X, Y.
  localparam int IR_W   = 9;
  localparam int OP_MSB = 8;
  localparam int X_MSB  = 5;
  localparam int Y_MSB  = 2;

endpackage

// File: rtl/proc_control_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
interface proc_control_if #(
  parameter int DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic              g_zero;
  logic              dinout;
  logic [7:0]        r_out;
  logic              g_out;
  logic              dout_out;
  logic [7:0]        r_in;
  logic              a_in;
  logic              g_in;
  logic              add_sub;
  logic              addr_in;
  logic              dout_in;
  logic              w_d;
  logic              done;

  modport master (
    input  run, din, g_zero,
    output dinout, r_out, g_out, dout_out, r_in, a_in, g_in, add_sub,
           addr_in, dout_in, w_d, done
  );

  modport slave (
    output run, din, g_zero,
    input  dinout, r_out, g_out, dout_out, r_in, a_in, g_in, add_sub,
           addr_in, dout_in, w_d, done
  );
endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control.sv
// Control FSM of the 8-register bus processor: latches the instruction on run
// and sequences bus selects and load enables over 1-3 execute cycles.
module proc_control
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic             clock,
  input logic             reset,
  proc_control_if.master  bus
);

  state_t          state;
  logic [IR_W-1:0] ir;
  logic [2:0]      op, rx, ry;

  logic       src_en, dst_en;
  logic [2:0] src_sel, dst_sel;
  logic [7:0] r_out_c, r_in_c;
  logic       dinout_c, g_out_c, a_in_c, g_in_c, add_sub_c;
  logic       addr_in_c, dout_in_c, w_d_c, done_c;

  assign op = ir[OP_MSB -: 3];
  assign rx = ir[X_MSB -: 3];
  assign ry = ir[Y_MSB -: 3];

  // done marks the final cycle of every instruction, so it alone decides
  // whether the sequence returns to IDLE or advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.run) begin
          ir    <= bus.din[DATA_W-1 -: IR_W];
          state <= S_T1;
        end
        S_T1:    state <= done_c ? S_IDLE : S_T2;
        S_T2:    state <= done_c ? S_IDLE : S_T3;
        S_T3:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_en    = 1'b0;
    src_sel   = 3'd0;
    dst_en    = 1'b0;
    dst_sel   = 3'd0;
    dinout_c  = 1'b0;
    g_out_c   = 1'b0;
    a_in_c    = 1'b0;
    g_in_c    = 1'b0;
    add_sub_c = 1'b0;
    addr_in_c = 1'b0;
    dout_in_c = 1'b0;
    w_d_c     = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_T1: case (op)
        OP_MV:   begin src_en = 1'b1; src_sel = ry; dst_en = 1'b1; dst_sel = rx; done_c = 1'b1; end
        OP_MVI:  begin dinout_c = 1'b1; dst_en = 1'b1; dst_sel = rx; done_c = 1'b1; end
        OP_ADD, OP_SUB: begin src_en = 1'b1; src_sel = rx; a_in_c = 1'b1; end
        OP_LD, OP_ST:   begin src_en = 1'b1; src_sel = ry; addr_in_c = 1'b1; end
        OP_MVNZ: begin
          src_en  = !bus.g_zero;
          src_sel = ry;
          dst_en  = !bus.g_zero;
          dst_sel = rx;
          done_c  = 1'b1;
        end
        default: done_c = 1'b1;
      endcase
      S_T2: case (op)
        OP_ADD, OP_SUB: begin
          src_en    = 1'b1;
          src_sel   = ry;
          g_in_c    = 1'b1;
          add_sub_c = (op == OP_SUB);
        end
        OP_ST: begin
          src_en    = 1'b1;
          src_sel   = rx;
          dout_in_c = 1'b1;
          w_d_c     = 1'b1;
          done_c    = 1'b1;
        end
        default: ;
      endcase
      // Load data arrives on din one cycle after the address was issued.
      S_T3: case (op)
        OP_ADD, OP_SUB: begin g_out_c = 1'b1; dst_en = 1'b1; dst_sel = rx; done_c = 1'b1; end
        OP_LD:          begin dinout_c = 1'b1; dst_en = 1'b1; dst_sel = rx; done_c = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end

  dec3to8 u_src_dec (
    .en  (src_en),
    .sel (src_sel),
    .y   (r_out_c)
  );

  dec3to8 u_dst_dec (
    .en  (dst_en),
    .sel (dst_sel),
    .y   (r_in_c)
  );

  assign bus.dinout   = dinout_c;
  assign bus.r_out    = r_out_c;
  assign bus.g_out    = g_out_c;
  assign bus.dout_out = 1'b0;
  assign bus.r_in     = r_in_c;
  assign bus.a_in     = a_in_c;
  assign bus.g_in     = g_in_c;
  assign bus.add_sub  = add_sub_c;
  assign bus.addr_in  = addr_in_c;
  assign bus.dout_in  = dout_in_c;
  assign bus.w_d      = w_d_c;
  assign bus.done     = done_c;

endmodule
